// File: rtl/vend_controller_pkg.sv
// rtl/vend_controller_pkg.sv - shared state encodings, coin values and sizing for the vending controller
package vend_controller_pkg;

  localparam int CREDIT_W   = 7;
  localparam int PRICE      = 15;
  localparam int MAX_CREDIT = 60;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_VEND   = 2'd2,
    ST_CHANGE = 2'd3
  } state_e;

  // Coin values in 5-cent units, one bit wider than credit so the ceiling compare cannot wrap
  localparam logic [CREDIT_W:0] COIN_5C  = (CREDIT_W+1)'(1);
  localparam logic [CREDIT_W:0] COIN_10C = (CREDIT_W+1)'(2);
  localparam logic [CREDIT_W:0] COIN_25C = (CREDIT_W+1)'(5);
  localparam logic [CREDIT_W:0] COIN_1D  = (CREDIT_W+1)'(20);

  function automatic logic [CREDIT_W:0] coin_value(input logic [1:0] code);
    case (code)
      2'b00:   return COIN_5C;
      2'b01:   return COIN_10C;
      2'b10:   return COIN_25C;
      default: return COIN_1D;
    endcase
  endfunction

endpackage

// File: rtl/vend_controller_tick_edge.sv
// rtl/vend_controller_tick_edge.sv - rising-edge detector for one timer tick, with a blanking input
module vend_controller_tick_edge (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic blank,
  output logic tick_rise
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = tick;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= prev_d;
  end

  // History keeps tracking while blanked so a level held across the blank window is not seen later
  assign tick_rise = tick & ~prev_q & ~blank;

endmodule

// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - vending-machine control FSM driving and consuming time_generator ticks
module vend_controller
  import vend_controller_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic                select,
  input  logic                cancel,
  input  logic                half_second,
  input  logic                three_seconds,
  input  logic                five_seconds,
  output logic                tmr_en,
  output logic                tmr_set,
  output logic [CREDIT_W-1:0] credit,
  output logic                dispense,
  output logic                change_pulse,
  output logic                coin_reject,
  output logic                busy
);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                tmr_en_q, tmr_en_d;
  logic                tmr_set_q, tmr_set_d;
  logic                set_dly_q, set_dly_d;
  logic                dispense_q, dispense_d;
  logic                change_pulse_q, change_pulse_d;
  logic                coin_reject_q, coin_reject_d;
  logic                busy_q, busy_d;

  logic                half_rise, three_rise, five_rise;
  logic                blank;
  logic [CREDIT_W:0]   sum;
  logic                coin_taken;

  // The timer clears one cycle after tmr_set, so ticks are ignored for two cycles
  assign blank = tmr_set_q | set_dly_q;

  vend_controller_tick_edge u_half (
    .clk(clk), .rst(rst), .tick(half_second), .blank(blank), .tick_rise(half_rise)
  );
  vend_controller_tick_edge u_three (
    .clk(clk), .rst(rst), .tick(three_seconds), .blank(blank), .tick_rise(three_rise)
  );
  vend_controller_tick_edge u_five (
    .clk(clk), .rst(rst), .tick(five_seconds), .blank(blank), .tick_rise(five_rise)
  );

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    change_pulse_d = 1'b0;
    coin_reject_d  = 1'b0;
    coin_taken     = 1'b0;
    sum            = {1'b0, credit_q} + coin_value(coin_type);

    case (state_q)
      ST_IDLE: begin
        if (coin_valid) begin
          credit_d = sum[CREDIT_W-1:0];
          state_d  = ST_CREDIT;
        end
      end
      ST_CREDIT: begin
        if (cancel) begin
          coin_reject_d = coin_valid;
          state_d       = ST_CHANGE;
        end else begin
          if (coin_valid) begin
            if (sum <= (CREDIT_W+1)'(MAX_CREDIT)) begin
              credit_d   = sum[CREDIT_W-1:0];
              coin_taken = 1'b1;
            end else begin
              coin_reject_d = 1'b1;
            end
          end
          // Select is judged on the credit before any same-cycle coin
          if (select && (credit_q >= CREDIT_W'(PRICE))) begin
            credit_d = credit_d - CREDIT_W'(PRICE);
            state_d  = ST_VEND;
          end else if (five_rise && !coin_valid) begin
            state_d = ST_CHANGE;
          end
        end
      end
      ST_VEND: begin
        coin_reject_d = coin_valid;
        if (three_rise) state_d = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
      end
      default: begin
        coin_reject_d = coin_valid;
        if (credit_q == '0) begin
          state_d = ST_IDLE;
        end else if (half_rise) begin
          change_pulse_d = 1'b1;
          credit_d       = credit_q - 1'b1;
          if (credit_q == CREDIT_W'(1)) state_d = ST_IDLE;
        end
      end
    endcase

    tmr_set_d  = ((state_d != state_q) && (state_d != ST_IDLE)) || coin_taken;
    tmr_en_d   = (state_d != ST_IDLE);
    dispense_d = (state_d == ST_VEND);
    busy_d     = (state_d == ST_VEND) || (state_d == ST_CHANGE);
    set_dly_d  = tmr_set_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      credit_q       <= '0;
      tmr_en_q       <= 1'b0;
      tmr_set_q      <= 1'b0;
      set_dly_q      <= 1'b0;
      dispense_q     <= 1'b0;
      change_pulse_q <= 1'b0;
      coin_reject_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      tmr_en_q       <= tmr_en_d;
      tmr_set_q      <= tmr_set_d;
      set_dly_q      <= set_dly_d;
      dispense_q     <= dispense_d;
      change_pulse_q <= change_pulse_d;
      coin_reject_q  <= coin_reject_d;
      busy_q         <= busy_d;
    end
  end

  assign tmr_en       = tmr_en_q;
  assign tmr_set      = tmr_set_q;
  assign credit       = credit_q;
  assign dispense     = dispense_q;
  assign change_pulse = change_pulse_q;
  assign coin_reject  = coin_reject_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_vend_controller.sv
// tb/tb_vend_controller.sv - scoreboard bench for vend_controller with directed coin/select/tick sequences
module tb_vend_controller;
  import vend_controller_pkg::*;

  localparam int EV_ON  = 0;
  localparam int EV_OFF = 1;
  localparam int EV_CHG = 2;
  localparam int EV_REJ = 3;
  localparam int T_HALF  = 0;
  localparam int T_THREE = 1;
  localparam int T_FIVE  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                coin_valid;
  logic [1:0]          coin_type;
  logic                select;
  logic                cancel;
  logic                half_second;
  logic                three_seconds;
  logic                five_seconds;
  logic                tmr_en;
  logic                tmr_set;
  logic [CREDIT_W-1:0] credit;
  logic                dispense;
  logic                change_pulse;
  logic                coin_reject;
  logic                busy;

  typedef struct {
    int kind;
    int cred;
  } ev_t;

  ev_t  exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic disp_prev = 1'b0;

  vend_controller dut (
    .clk(clk), .rst(rst),
    .coin_valid(coin_valid), .coin_type(coin_type),
    .select(select), .cancel(cancel),
    .half_second(half_second), .three_seconds(three_seconds), .five_seconds(five_seconds),
    .tmr_en(tmr_en), .tmr_set(tmr_set), .credit(credit),
    .dispense(dispense), .change_pulse(change_pulse), .coin_reject(coin_reject), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  function automatic void expect_ev(input int k, input int c);
    ev_t e;
    e.kind = k;
    e.cred = c;
    exp_q.push_back(e);
  endfunction

  task automatic take(input int k);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL event: unexpected kind %0d at credit %0d, expected none", k, credit);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cred != int'(credit)) begin
        n_bad++;
        $display("FAIL event: got kind %0d credit %0d expected kind %0d credit %0d",
                 k, credit, e.kind, e.cred);
      end
    end
  endtask

  // Monitor: every output event is matched in order against the expectation queue
  always @(negedge clk) begin
    if (dispense === 1'b1 && !disp_prev) take(EV_ON);
    if (dispense === 1'b0 && disp_prev)  take(EV_OFF);
    if (change_pulse === 1'b1)           take(EV_CHG);
    if (coin_reject === 1'b1)            take(EV_REJ);
    disp_prev = (dispense === 1'b1);
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic coin(input logic [1:0] t);
    coin_valid = 1'b1;
    coin_type  = t;
    cyc(1);
    coin_valid = 1'b0;
  endtask

  task automatic buy();
    select = 1'b1;
    cyc(1);
    select = 1'b0;
  endtask

  task automatic tick(input int which);
    half_second   = (which == T_HALF);
    three_seconds = (which == T_THREE);
    five_seconds  = (which == T_FIVE);
    cyc(1);
    half_second   = 1'b0;
    three_seconds = 1'b0;
    five_seconds  = 1'b0;
    cyc(1);
  endtask

  task automatic drain(input int from);
    for (int i = from - 1; i >= 0; i--) begin
      expect_ev(EV_CHG, i);
      tick(T_HALF);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    coin_valid = 1'b0; coin_type = 2'b00; select = 1'b0; cancel = 1'b0;
    half_second = 1'b0; three_seconds = 1'b0; five_seconds = 1'b0;
    #2;
    check("reset_outputs", {26'd0, tmr_en, tmr_set, dispense, change_pulse, coin_reject, busy}, 32'd0);
    check("reset_credit", credit, 0);
    cyc(2);
    rst = 1'b0;
    cyc(2);

    // 1: exact price, no change
    coin(2'b10); coin(2'b10); coin(2'b10);
    check("t1_credit15", credit, 15);
    expect_ev(EV_ON, 0);
    buy();
    check("t1_vend_busy", busy, 1);
    cyc(3);
    expect_ev(EV_OFF, 0);
    tick(T_THREE);
    check("t1_idle_busy", busy, 0);
    check("t1_idle_tmr_en", tmr_en, 0);

    // 2: $1 then select, five coins change
    coin(2'b11);
    check("t2_credit20", credit, 20);
    expect_ev(EV_ON, 5);
    buy();
    cyc(3);
    expect_ev(EV_OFF, 5);
    tick(T_THREE);
    check("t2_change_busy", busy, 1);
    cyc(3);
    drain(5);
    check("t2_idle_busy", busy, 0);
    check("t2_credit0", credit, 0);

    // 3: inactivity timeout refunds
    coin(2'b10);
    cyc(3);
    tick(T_FIVE);
    check("t3_change_busy", busy, 1);
    cyc(3);
    drain(5);
    check("t3_tmr_en", tmr_en, 0);
    check("t3_idle_busy", busy, 0);

    // 4: ceiling rejection at 58
    coin(2'b11); coin(2'b11); coin(2'b10); coin(2'b10); coin(2'b10); coin(2'b01); coin(2'b00);
    check("t4_credit58", credit, 58);
    expect_ev(EV_REJ, 58);
    coin(2'b11);
    check("t4_no_tmr_set", tmr_set, 0);
    check("t4_credit_kept", credit, 58);
    check("t4_still_credit", {30'd0, tmr_en, busy}, 32'd2);
    cancel = 1'b1;
    cyc(1);
    cancel = 1'b0;
    check("t4_cancel_busy", busy, 1);
    cyc(3);
    drain(58);
    check("t4_idle_busy", busy, 0);

    // 5: cancel + select + coin in one cycle
    coin(2'b11);
    cyc(3);
    expect_ev(EV_REJ, 20);
    cancel = 1'b1; select = 1'b1; coin_valid = 1'b1; coin_type = 2'b00;
    cyc(1);
    cancel = 1'b0; select = 1'b0; coin_valid = 1'b0;
    check("t5_change_busy", busy, 1);
    check("t5_no_dispense", dispense, 0);
    check("t5_credit20", credit, 20);
    cyc(3);
    drain(20);
    check("t5_idle_busy", busy, 0);

    // 6: asynchronous reset during VEND, then a normal purchase
    coin(2'b10); coin(2'b10); coin(2'b10);
    expect_ev(EV_ON, 0);
    buy();
    cyc(1);
    expect_ev(EV_OFF, 0);
    #2 rst = 1'b1;
    #1;
    check("t6_async_dispense", dispense, 0);
    check("t6_async_state", {30'd0, tmr_en, busy}, 32'd0);
    check("t6_async_credit", credit, 0);
    cyc(2);
    rst = 1'b0;
    cyc(1);
    coin(2'b10);
    check("t6_new_credit", credit, 5);
    check("t6_new_tmr_en", tmr_en, 1);
    check("t6_new_tmr_set", tmr_set, 1);
    coin(2'b10); coin(2'b10);
    expect_ev(EV_ON, 0);
    buy();
    cyc(3);
    expect_ev(EV_OFF, 0);
    tick(T_THREE);
    check("t6_idle_busy", busy, 0);

    cyc(3);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
